// File: rtl/ddr4_writer_xk.sv
// Kalman X_k write-back: buffers state vectors and stores each one to DDR4
// as a single AXI4 INCR burst at a fixed per-iteration stride.
module ddr4_writer_xk #(
  parameter int unsigned STATE_DIM      = 12,
  parameter int unsigned MAX_ITERATIONS = 100,
  parameter logic [31:0] ADDR_XK_BASE   = 32'h0080_0000,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_write,
  input  logic [STATE_DIM-1:0][63:0] X_k_in,
  input  logic                       X_k_valid_in,
  output logic                       X_k_ready_out,
  output logic [31:0]                axi_awaddr,
  output logic [7:0]                 axi_awlen,
  output logic [2:0]                 axi_awsize,
  output logic [1:0]                 axi_awburst,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [511:0]               axi_wdata,
  output logic [63:0]                axi_wstrb,
  output logic                       axi_wlast,
  output logic                       axi_wvalid,
  input  logic                       axi_wready,
  input  logic [1:0]                 axi_bresp,
  input  logic                       axi_bvalid,
  output logic                       axi_bready,
  output logic                       all_X_k_written,
  output logic                       write_error,
  output logic                       busy
);

  localparam int unsigned BEATS  = (STATE_DIM * 8 + 63) / 64;
  localparam int unsigned STRIDE = BEATS * 64;
  localparam int unsigned LANES  = BEATS * 8;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_ITERATIONS + 1);

  typedef logic [STATE_DIM-1:0][63:0] vec_t;
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   widx_q, widx_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  vec_t            mem_q [FIFO_DEPTH];

  logic push, pop;
  vec_t head;
  logic [LANES-1:0][63:0] pad;
  logic [LANES-1:0][7:0]  spad;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign X_k_ready_out = busy_q & ~done_q
                       & (cnt_q < CW'(FIFO_DEPTH))
                       & (acc_q < IW'(MAX_ITERATIONS));
  assign push = X_k_valid_in & X_k_ready_out;
  assign pop  = (state_q == S_B) & axi_bvalid;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    widx_d    = widx_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (busy_q && cnt_q != '0) begin
          awaddr_d  = ADDR_XK_BASE + 32'(widx_q) * 32'(STRIDE);
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end
      end
      S_AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (axi_wready) begin
          if (beat_q == BW'(BEATS - 1)) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = S_B;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_B: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          widx_d   = widx_q + IW'(1);
          if (axi_bresp != 2'b00) err_d = 1'b1;
          if (widx_q + IW'(1) == IW'(MAX_ITERATIONS)) done_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_write && !busy_q) begin
      busy_d = 1'b1;
      acc_d  = '0;
      widx_d = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (busy_q && done_q && !start_write) busy_d = 1'b0;
      if (push) begin
        wptr_d = nxt(wptr_q);
        acc_d  = acc_q + IW'(1);
      end
      if (pop) rptr_d = nxt(rptr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      beat_q    <= '0;
      acc_q     <= '0;
      widx_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      widx_q    <= widx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload storage needs no reset; it is only read behind wvalid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= X_k_in;
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    pad = '0;
    pad[STATE_DIM-1:0] = head;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_strb
    assign spad[g] = (g < STATE_DIM) ? 8'hFF : 8'h00;
  end

  assign axi_wdata   = wvalid_q ? pad[{beat_q, 3'b000} +: 8] : '0;
  assign axi_wstrb   = wvalid_q ? spad[{beat_q, 3'b000} +: 8] : '0;
  assign axi_wlast   = wvalid_q & (beat_q == BW'(BEATS - 1));
  assign axi_wvalid  = wvalid_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = 8'(BEATS - 1);
  assign axi_awsize  = 3'b110;
  assign axi_awburst = 2'b01;
  assign axi_bready  = bready_q;

  assign all_X_k_written = done_q;
  assign write_error     = err_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_ddr4_writer_xk.sv
// Scoreboard bench for ddr4_writer_xk: the driver queues expected AW/W
// traffic, a negedge monitor pops and compares it as the DUT presents it.
module tb_ddr4_writer_xk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_write = 1'b0;
  logic [11:0][63:0] X_k_in = '0;
  logic X_k_valid_in = 1'b0;
  logic X_k_ready_out;
  logic [31:0] axi_awaddr;
  logic [7:0] axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_awvalid;
  logic axi_awready = 1'b0;
  logic [511:0] axi_wdata;
  logic [63:0] axi_wstrb;
  logic axi_wlast;
  logic axi_wvalid;
  logic axi_wready = 1'b0;
  logic [1:0] axi_bresp = 2'b00;
  logic axi_bvalid = 1'b0;
  logic axi_bready;
  logic all_X_k_written;
  logic write_error;
  logic busy;

  ddr4_writer_xk dut (
    .clk(clk), .rst_n(rst_n), .start_write(start_write),
    .X_k_in(X_k_in), .X_k_valid_in(X_k_valid_in),
    .X_k_ready_out(X_k_ready_out),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .all_X_k_written(all_X_k_written),
    .write_error(write_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  s;
    logic         l;
  } beat_t;

  logic [31:0] exp_aw[$];
  beat_t       exp_w[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int sent = 0;
  int bdone = 0;
  int aw_acc = 0;
  int w_bursts = 0;
  int err_at = -1;
  logic exp_err = 1'b0;
  logic rnd = 1'b0;
  logic hold_w = 1'b0;
  logic [31:0] last_aw = '0;

  task automatic chkw(input string nm, input logic [511:0] act,
                      input logic [511:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0b required %0b", nm, act, req);
  endtask

  task automatic timeout(input string nm);
    total_cnt++;
    $display("FAIL %s: got timeout required event", nm);
  endtask

  function automatic logic [63:0] elem(input int v, input int i);
    return {32'(v), 32'h1000 + 32'(i)};
  endfunction

  task automatic push_expect(input int v, input int sidx);
    beat_t b0, b1;
    exp_aw.push_back(32'h0080_0000 + 32'(sidx) * 32'd128);
    b0 = '0;
    b1 = '0;
    for (int j = 0; j < 8; j++) b0.d[j*64 +: 64] = elem(v, j);
    for (int j = 0; j < 4; j++) b1.d[j*64 +: 64] = elem(v, 8 + j);
    b0.s = '1;
    b1.s = 64'h0000_0000_FFFF_FFFF;
    b0.l = 1'b0;
    b1.l = 1'b1;
    exp_w.push_back(b0);
    exp_w.push_back(b1);
  endtask

  // Slave model: readies and B response, updated just after each edge.
  always begin
    @(posedge clk);
    #1;
    axi_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (hold_w) axi_wready = !axi_wlast;
    else axi_wready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    axi_bvalid = axi_bready && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
    axi_bresp = (bdone == err_at) ? 2'b10 : 2'b00;
  end

  logic aw_stall = 1'b0;
  logic w_stall = 1'b0;
  logic [31:0] aw_prev = '0;
  beat_t w_prev = '0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_aw.delete();
      exp_w.delete();
      aw_acc = 0;
      w_bursts = 0;
      bdone = 0;
      exp_err = 1'b0;
      aw_stall = 1'b0;
      w_stall = 1'b0;
    end else begin
      if (start_write && !busy) begin
        bdone = 0;
        exp_err = 1'b0;
      end
      if (aw_stall) begin
        chk1("aw_hold_valid", axi_awvalid, 1'b1);
        chkw("aw_hold_addr", 512'(axi_awaddr), 512'(aw_prev));
      end
      if (axi_awvalid && axi_awready) begin
        if (exp_aw.size() == 0) timeout("aw_unexpected");
        else chkw("awaddr", 512'(axi_awaddr), 512'(exp_aw.pop_front()));
        chkw("awlen", 512'(axi_awlen), 512'(8'd1));
        chkw("awsize", 512'(axi_awsize), 512'(3'b110));
        chkw("awburst", 512'(axi_awburst), 512'(2'b01));
        last_aw = axi_awaddr;
        aw_acc++;
      end
      aw_stall = axi_awvalid && !axi_awready;
      aw_prev = axi_awaddr;

      if (w_stall) begin
        chk1("w_hold_valid", axi_wvalid, 1'b1);
        chkw("w_hold_data", axi_wdata, w_prev.d);
        chkw("w_hold_strb", 512'(axi_wstrb), 512'(w_prev.s));
        chk1("w_hold_last", axi_wlast, w_prev.l);
      end
      if (axi_wvalid) begin
        chk1("w_after_aw", aw_acc > w_bursts, 1'b1);
        if (axi_wready) begin
          if (exp_w.size() == 0) timeout("w_unexpected");
          else begin
            e = exp_w.pop_front();
            chkw("wdata", axi_wdata, e.d);
            chkw("wstrb", 512'(axi_wstrb), 512'(e.s));
            chk1("wlast", axi_wlast, e.l);
          end
          if (axi_wlast) w_bursts++;
        end
      end
      w_stall = axi_wvalid && !axi_wready;
      w_prev = '{d: axi_wdata, s: axi_wstrb, l: axi_wlast};

      if (axi_bvalid && axi_bready) begin
        chk1("b_err_before", write_error, exp_err);
        chk1("b_done_before", all_X_k_written, 1'b0);
        exp_err = exp_err | (axi_bresp != 2'b00);
        bdone++;
      end
    end
  end

  task automatic start_session();
    @(posedge clk);
    #1;
    start_write = 1'b1;
    sent = 0;
    @(posedge clk);
    #1;
    start_write = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start_write = 1'b1;
    @(posedge clk);
    #1;
    start_write = 1'b0;
  endtask

  task automatic send_vec(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) X_k_in[i] = elem(v, i);
    X_k_valid_in = 1'b1;
    forever begin
      @(negedge clk);
      if (X_k_ready_out) break;
      n++;
      if (n > 2000) break;
    end
    if (n > 2000) begin
      timeout("send_ready");
      X_k_valid_in = 1'b0;
    end else begin
      push_expect(v, sent);
      @(posedge clk);
      #1;
      X_k_valid_in = 1'b0;
      sent++;
      chk1("fifo_le_2", (sent - bdone) <= 2, 1'b1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bdone != sent) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 3000) begin
        timeout("drain");
        break;
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_awvalid", axi_awvalid, 1'b0);
    chk1("rst_wvalid", axi_wvalid, 1'b0);
    chk1("rst_bready", axi_bready, 1'b0);
    chk1("rst_ready", X_k_ready_out, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", all_X_k_written, 1'b0);
    chk1("rst_err", write_error, 1'b0);
    chk1("rst_wlast", axi_wlast, 1'b0);
    chkw("rst_awaddr", 512'(axi_awaddr), 512'(32'h0));
    chkw("rst_wdata", axi_wdata, 512'h0);
    chkw("rst_wstrb", 512'(axi_wstrb), 512'(64'h0));
    chkw("rst_awlen", 512'(axi_awlen), 512'(8'd1));
    rst_n = 1'b1;

    err_at = 3;
    rnd = 1'b0;
    start_session();
    chk1("a_busy", busy, 1'b1);
    chk1("a_ready", X_k_ready_out, 1'b1);
    send_vec(0);
    chk1("first_aw_not_yet", axi_awvalid, 1'b0);
    @(posedge clk);
    #1;
    chk1("first_aw_valid", axi_awvalid, 1'b1);
    chkw("first_aw_addr", 512'(axi_awaddr), 512'(32'h0080_0000));
    for (int v = 1; v < 100; v++) begin
      if (v == 50) pulse_start();
      send_vec(v);
    end
    drain();
    chk1("a_done", all_X_k_written, 1'b1);
    chk1("a_busy_hold", busy, 1'b1);
    chk1("a_ready_off", X_k_ready_out, 1'b0);
    chk1("a_err_sticky", write_error, 1'b1);
    chkw("a_last_addr", 512'(last_aw), 512'(32'h0080_3180));
    chkw("a_sb_empty", 512'(exp_aw.size() + exp_w.size()), 512'(0));
    for (int i = 0; i < 12; i++) X_k_in[i] = elem(101, i);
    X_k_valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("extra_ready", X_k_ready_out, 1'b0);
    end
    @(posedge clk);
    #1;
    X_k_valid_in = 1'b0;
    chk1("a_busy_end", busy, 1'b0);
    chk1("a_done_kept", all_X_k_written, 1'b1);

    err_at = -1;
    rnd = 1'b1;
    start_session();
    chk1("b_err_clr", write_error, 1'b0);
    chk1("b_done_clr", all_X_k_written, 1'b0);
    chk1("b_busy", busy, 1'b1);
    for (int k = 0; k < 9; k++) send_vec(200 + k);
    hold_w = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (axi_wvalid && axi_wlast && !axi_wready) break;
      n++;
      if (n > 2000) break;
    end
    if (n > 2000) timeout("wait_beat1");
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_awvalid", axi_awvalid, 1'b0);
    chk1("mid_rst_wvalid", axi_wvalid, 1'b0);
    chk1("mid_rst_wlast", axi_wlast, 1'b0);
    chk1("mid_rst_bready", axi_bready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", X_k_ready_out, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_w = 1'b0;
    rnd = 1'b0;

    start_session();
    send_vec(85);
    drain();
    chkw("c_sb_empty", 512'(exp_aw.size() + exp_w.size()), 512'(0));
    chkw("c_addr", 512'(last_aw), 512'(32'h0080_0000));
    chk1("c_busy", busy, 1'b1);
    chk1("c_err", write_error, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ddr4_writer_xk.md
# ddr4_writer_xk

Write-back stage that takes the Kalman filter's updated state vector X_k (one per iteration) and stores it to DDR4 over an AXI4 write master at a fixed per-iteration stride. It sits downstream of the filter core and mirrors the measurement read path on the write side. Each vector becomes one INCR burst. The block raises a done flag after MAX_ITERATIONS vectors have been acknowledged.

## Interface
Parameters:
- STATE_DIM, 12: number of 64-bit state elements per vector.
- MAX_ITERATIONS, 100: vectors per session.
- ADDR_XK_BASE, 32'h0080_0000: byte address of vector 0.
- FIFO_DEPTH, 2: input vector buffer entries (≥1).
- Derived: BEATS = ceil(STATE_DIM*8/64), STRIDE = BEATS*64 bytes (12 → 2 beats, 128 B).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_write  in  1  level; starts a session when idle.
- X_k_in  in  64 × [STATE_DIM-1:0]  state vector; element i is at byte offset 8*i.
- X_k_valid_in  in  1  X_k_in is valid.
- X_k_ready_out  out  1  block can accept a vector.
- axi_awaddr  out  32, axi_awlen  out  8 (=BEATS-1), axi_awsize  out  3 (=3'b110), axi_awburst  out  2 (=2'b01), axi_awvalid  out  1, axi_awready  in  1.
- axi_wdata  out  512, axi_wstrb  out  64, axi_wlast  out  1, axi_wvalid  out  1, axi_wready  in  1.
- axi_bresp  in  2, axi_bvalid  in  1, axi_bready  out  1.
- all_X_k_written  out  1  sticky: session complete.
- write_error  out  1  sticky: a non-OKAY bresp was received this session.
- busy  out  1  session running.

## Operation
- Reset: every output is 0 (awlen/awsize/awburst are constants). FSM = IDLE. FIFO is empty. Counters = 0.
- Session start: start_write=1 while busy=0 sets busy. It clears accept_idx, write_idx, all_X_k_written, write_error and the FIFO. start_write is ignored while busy.
- Session end: while all_X_k_written=1 and start_write=0, busy clears.
- Input: X_k_ready_out = busy & !all_X_k_written & fifo_count<FIFO_DEPTH & accept_idx<MAX_ITERATIONS.
  - On valid&ready, write the vector into the FIFO and increment accept_idx.
  - Push and pop in the same cycle are legal: the count is unchanged.
- FSM:
  - IDLE: when the FIFO is non-empty, register axi_awaddr = ADDR_XK_BASE + write_idx*STRIDE (mod 2^32), set awvalid=1, go to AW.
  - AW: hold address and awvalid until awready. On handshake, drop awvalid, set beat=0, present beat 0 with wvalid=1, go to W. W never leads AW.
  - W: wdata beat b = elements 8b..8b+7 of the FIFO head; lanes past STATE_DIM are 0.
    - wstrb: 1 for the bytes that hold elements, 0 otherwise. For 12 elements: beat 0 = all ones, beat 1 = 64'h0000_0000_FFFF_FFFF.
    - wlast = (beat==BEATS-1).
    - On wready, advance beat. After the last handshake, drop wvalid and go to B with bready=1.
    - wdata/wstrb/wlast stay stable while wvalid & !wready.
  - B: on bvalid, drop bready, pop the FIFO head, increment write_idx. If bresp≠2'b00, set write_error (no retry). Go to IDLE.
    - If write_idx+1 == MAX_ITERATIONS, set all_X_k_written in the same cycle.
- The FIFO entry is popped only on the B response; data is held until acknowledged.
- Reset mid-burst: rst_n low at any time forces the reset state immediately. Valids drop asynchronously; no completion of the outstanding burst is attempted.

## Timing
- Vector accepted at edge T, FIFO previously empty, FSM in IDLE: awvalid=1 after edge T+1.
- With awready, wready and bvalid tied high, one vector occupies:
  - IDLE 1 cycle, AW 1, W BEATS, B 1.
  - That is BEATS+3 cycles (5 for STATE_DIM=12) from the awvalid-setting edge to the next return to IDLE.
- Backpressure on any channel stretches only that state; there is no timeout.
- Only one burst is outstanding at a time.
- X_k_ready_out is registered-state based. It may rise the cycle after a pop.

## Test plan
- Single vector, all readies high, X_k_in[i]=64'h1000+i → one AW at 32'h0080_0000, awlen=1, beat 0 = elements 0-7, beat 1 = elements 8-11 with upper 256 bits zero, wstrb 64'h0000_0000_FFFF_FFFF, wlast on beat 1 only, write_idx=1.
- 100 back-to-back vectors → addresses step by 128 (last = 32'h0080_3180); all_X_k_written=1 with the 100th bvalid; X_k_ready_out=0 after it; the 101st valid is not accepted.
- Random awready/wready/bvalid stalls (0-5 cycles) → AW/W signals stable under stall, no W before AW accepted, data matches order, FIFO never exceeds 2.
- bresp=2'b10 on vector 3 → write_error=1 and stays 1, remaining vectors still written, cleared by next session start.
- rst_n asserted during W beat 1 → all valids/bready 0 immediately, busy=0; new start_write then writes vector 0 at the base address.
- start_write pulsed while busy → no effect on counters; after completion with start_write low, busy=0.
